// File: rtl/kairo_div.sv
// kairo_div: iterative RV32M DIV/DIVU/REM/REMU unit, radix-2 restoring, 32 steps plus sign fix-up.
// Optional KAIRO_DIV_FAST_EN retires divide-by-zero, signed overflow and |RS1|<|RS2| in one cycle.
module kairo_div #(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            INST_DIV,
    input  logic            INST_DIVU,
    input  logic            INST_REM,
    input  logic            INST_REMU,
    input  logic [XLEN-1:0] RS1,
    input  logic [XLEN-1:0] RS2,
    output logic            WAIT,
    output logic            READY,
    output logic [XLEN-1:0] RD
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] rem_q, dvd_q, dsr_q, rs1_q, res_q;
    logic            ready_q, is_rem_q, neg_q_q, neg_r_q, dz_q, ovf_q;

    logic            inst_div, signed_op, rem_op, dz_s, ovf_s, neg_q_s, neg_r_s;
    logic [XLEN-1:0] abs1, abs2;
    logic            fast_hit;
    logic [XLEN-1:0] fast_res;

    assign inst_div  = INST_DIV | INST_DIVU | INST_REM | INST_REMU;
    assign signed_op = INST_DIV | INST_REM;
    assign rem_op    = INST_REM | INST_REMU;
    assign abs1      = (signed_op && RS1[XLEN-1]) ? -RS1 : RS1;
    assign abs2      = (signed_op && RS2[XLEN-1]) ? -RS2 : RS2;
    assign dz_s      = (RS2 == '0);
    assign ovf_s     = signed_op && (RS1 == {1'b1, {(XLEN-1){1'b0}}}) && (RS2 == '1);
    assign neg_q_s   = signed_op & (RS1[XLEN-1] ^ RS2[XLEN-1]);
    assign neg_r_s   = signed_op & RS1[XLEN-1];

`ifdef KAIRO_DIV_FAST_EN
    logic lt_s;
    assign lt_s     = (abs1 < abs2);
    assign fast_hit = dz_s | ovf_s | lt_s;
    // Overflow quotient is 0x80000000, which is RS1 itself in that case.
    assign fast_res = dz_s  ? (rem_op ? RS1 : '1) :
                      ovf_s ? (rem_op ? '0  : RS1) :
                              (rem_op ? RS1 : '0);
`else
    assign fast_hit = 1'b0;
    assign fast_res = '0;
`endif

    // One restoring step: shift {rem, dividend}, trial-subtract, quotient bit into the dividend LSB.
    logic [XLEN:0]   sh;
    logic            qbit;
    logic [XLEN-1:0] rem_d, dvd_d, q_fix, r_fix, calc_res;

    assign sh    = {rem_q, dvd_q[XLEN-1]};
    assign qbit  = (sh >= {1'b0, dsr_q});
    assign rem_d = qbit ? (sh[XLEN-1:0] - dsr_q) : sh[XLEN-1:0];
    assign dvd_d = {dvd_q[XLEN-2:0], qbit};
    assign q_fix = neg_q_q ? -dvd_d : dvd_d;
    assign r_fix = neg_r_q ? -rem_d : rem_d;

    assign calc_res = dz_q  ? (is_rem_q ? rs1_q : '1) :
                      ovf_q ? (is_rem_q ? '0 : {1'b1, {(XLEN-1){1'b0}}}) :
                              (is_rem_q ? r_fix : q_fix);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            dvd_q    <= '0;
            dsr_q    <= '0;
            rs1_q    <= '0;
            res_q    <= '0;
            ready_q  <= 1'b0;
            is_rem_q <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b0;
                    if (inst_div) begin
                        cnt_q    <= CW'(XLEN-1);
                        rem_q    <= '0;
                        dvd_q    <= abs1;
                        dsr_q    <= abs2;
                        rs1_q    <= RS1;
                        is_rem_q <= rem_op;
                        neg_q_q  <= neg_q_s;
                        neg_r_q  <= neg_r_s;
                        dz_q     <= dz_s;
                        ovf_q    <= ovf_s;
                        if (fast_hit) begin
                            res_q   <= fast_res;
                            ready_q <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    // A dropped strobe is a pipeline flush: abandon the divide silently.
                    if (!inst_div) begin
                        state_q <= IDLE;
                    end else begin
                        rem_q <= rem_d;
                        dvd_q <= dvd_d;
                        cnt_q <= cnt_q - CW'(1);
                        if (cnt_q == '0) begin
                            res_q   <= calc_res;
                            ready_q <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    ready_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign READY = ready_q;
    assign RD    = ready_q ? res_q : '0;
    assign WAIT  = inst_div & ~ready_q;

endmodule

// File: tb/tb_kairo_div.sv
// Self-checking bench for kairo_div: directed RV32M corner cases plus random ops against an arithmetic model.
// Define KAIRO_DIV_FAST_EN for both files to check the fast-path latency.
module tb_kairo_div;
    logic        CLK = 1'b0;
    logic        RST;
    logic        INST_DIV, INST_DIVU, INST_REM, INST_REMU;
    logic [31:0] RS1, RS2;
    logic        WAIT, READY;
    logic [31:0] RD;

    int n_chk = 0;
    int n_err = 0;

    kairo_div #(.XLEN(32)) dut (
        .CLK(CLK), .RST(RST),
        .INST_DIV(INST_DIV), .INST_DIVU(INST_DIVU), .INST_REM(INST_REM), .INST_REMU(INST_REMU),
        .RS1(RS1), .RS2(RS2), .WAIT(WAIT), .READY(READY), .RD(RD)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // kind: 0 DIV, 1 DIVU, 2 REM, 3 REMU
    function automatic void ref_model(input int kind, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] res, output int lat);
        bit          sgn, isrem, ovf;
        logic [31:0] q, r;
        longint      ma, mb;
        sgn   = (kind == 0) || (kind == 2);
        isrem = (kind >= 2);
        ovf   = sgn && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        if (b == 0) begin
            q = 32'hFFFF_FFFF; r = a;
        end else if (ovf) begin
            q = 32'h8000_0000; r = 0;
        end else if (sgn) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        res = isrem ? r : q;
        ma = sgn ? longint'($signed(a)) : longint'(a);
        mb = sgn ? longint'($signed(b)) : longint'(b);
        if (ma < 0) ma = -ma;
        if (mb < 0) mb = -mb;
        lat = 33;
`ifdef KAIRO_DIV_FAST_EN
        if (b == 0 || ovf || ma < mb) lat = 1;
`endif
    endfunction

    task automatic set_op(input int kind, input bit en);
        INST_DIV  = en && kind == 0;
        INST_DIVU = en && kind == 1;
        INST_REM  = en && kind == 2;
        INST_REMU = en && kind == 3;
    endtask

    task automatic run_op(input int kind, input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [31:0] exp;
        int          lat, n;
        bit          hold_ok;
        ref_model(kind, a, b, exp, lat);
        @(negedge CLK);
        set_op(kind, 1'b1);
        RS1 = a;
        RS2 = b;
        #1;
        chk({tag, ".wait0"}, {31'b0, WAIT}, 32'd1);
        chk({tag, ".rdy0"}, {31'b0, READY}, 32'd0);
        n = 0;
        hold_ok = 1'b1;
        while (n < 40) begin
            @(posedge CLK); #1;
            n++;
            RS1 = $urandom;
            RS2 = $urandom;
            if (READY) break;
            if (!WAIT || RD != 0) hold_ok = 1'b0;
        end
        chk({tag, ".lat"}, n, lat);
        chk({tag, ".rd"}, RD, exp);
        chk({tag, ".waitrdy"}, {31'b0, WAIT}, 32'd0);
        chk({tag, ".hold"}, {31'b0, hold_ok}, 32'd1);
        @(negedge CLK);
        set_op(0, 1'b0);
        @(posedge CLK); #1;
        chk({tag, ".pulse1"}, {31'b0, READY, RD[0]}, 32'd0);
    endtask

    initial begin
        bit          seen;
        logic [31:0] a, b;
        int          kind;
        RST = 1'b1;
        set_op(0, 1'b0);
        RS1 = 0;
        RS2 = 0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst.ready", {31'b0, READY}, 32'd0);
        chk("rst.rd", RD, 32'd0);
        chk("rst.wait", {31'b0, WAIT}, 32'd0);
        @(negedge CLK);
        RST = 1'b0;

        run_op(0, 32'd20, 32'hFFFF_FFFD, "div_neg");
        run_op(2, 32'd20, 32'hFFFF_FFFD, "rem_neg");
        run_op(1, 32'hFFFF_FFFF, 32'd16, "divu");
        run_op(3, 32'hFFFF_FFFF, 32'd16, "remu");
        run_op(0, 32'd7, 32'd0, "div_z");
        run_op(2, 32'd7, 32'd0, "rem_z");
        run_op(1, 32'hDEAD_BEEF, 32'd0, "divu_z");
        run_op(0, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        run_op(2, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
        run_op(0, 32'hFFFF_FFF9, 32'd100, "div_small");

        // Flush: strobe low during cycle 10, then restart right away in cycle 11.
        @(negedge CLK);
        set_op(1, 1'b1);
        RS1 = 32'd100;
        RS2 = 32'd7;
        seen = 1'b0;
        repeat (10) begin
            @(posedge CLK); #1;
            if (READY) seen = 1'b1;
        end
        set_op(0, 1'b0);
        @(posedge CLK); #1;
        if (READY) seen = 1'b1;
        chk("abort.noready", {31'b0, seen}, 32'd0);
        run_op(1, 32'd100, 32'd7, "after_abort");

        // Reset in the middle of a divide.
        @(negedge CLK);
        set_op(0, 1'b1);
        RS1 = 32'hFFFF_FC18;
        RS2 = 32'd7;
        repeat (15) @(posedge CLK);
        #1;
        RST = 1'b1;
        #1;
        chk("midrst.ready", {31'b0, READY}, 32'd0);
        chk("midrst.rd", RD, 32'd0);
        @(negedge CLK);
        set_op(0, 1'b0);
        @(negedge CLK);
        RST = 1'b0;
        run_op(0, 32'hFFFF_FC18, 32'd7, "after_rst");

        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 3);
            a = $urandom;
            case ($urandom_range(0, 7))
                0: b = 0;
                1: begin b = 32'hFFFF_FFFF; if ($urandom_range(0, 1) == 1) a = 32'h8000_0000; end
                2: b = $urandom_range(1, 20);
                3: b = a;
                4: begin b = $urandom; a = a >> $urandom_range(0, 31); end
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            run_op(kind, a, b, $sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
